// File: rtl/vram_row_clear_sequencer_if.sv
// VRAM port-A bus bundle shared by the Avalon host path and the row-clear engine.
// The slave side is the sequencer: it receives host requests and RAM read data,
// and drives the host grant and the physical RAM port.
interface vram_row_clear_sequencer_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic                  host_req;
  logic                  host_we;
  logic [ADDR_W-1:0]     host_addr;
  logic [DATA_W-1:0]     host_wdata;
  logic [DATA_W/8-1:0]   host_be;
  logic                  host_grant;
  logic [ADDR_W-1:0]     ram_addr;
  logic [DATA_W-1:0]     ram_wdata;
  logic [DATA_W/8-1:0]   ram_be;
  logic                  ram_wren;
  logic                  ram_rden;
  logic [DATA_W-1:0]     ram_q;

  modport master (
    output host_req, host_we, host_addr, host_wdata, host_be, ram_q,
    input  host_grant, ram_addr, ram_wdata, ram_be, ram_wren, ram_rden
  );

  modport slave (
    input  host_req, host_we, host_addr, host_wdata, host_be, ram_q,
    output host_grant, ram_addr, ram_wdata, ram_be, ram_wren, ram_rden
  );
endinterface

// File: rtl/vram_row_clear_sequencer.sv
// Tetris line-clear engine working directly on text-VRAM.
// Row r occupancy is word r, its colour word is r+COLOR_BASE. A pass walks
// src from the bottom row up, drops full rows, copies surviving rows down to
// dst, then zeroes the rows left free at the top. While a pass runs the
// engine owns VRAM port A and the host path is stalled.
module vram_row_clear_sequencer #(
  parameter int ROWS       = 20,
  parameter int COLS       = 10,
  parameter int COLOR_BASE = 40,
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [4:0]                 lines_cleared,
  vram_row_clear_sequencer_if.slave  bus
);

  localparam int RW = $clog2(ROWS);
  // dst carries one extra sign bit so that stepping past row 0 reads as -1
  localparam int DW = RW + 1;
  localparam logic [RW-1:0]        SRC_TOP = RW'(ROWS - 1);
  localparam logic signed [DW-1:0] DST_TOP = DW'(ROWS - 1);
  localparam logic signed [DW-1:0] ONE_S   = DW'(1);
  localparam logic [ADDR_W-1:0]    CB      = ADDR_W'(COLOR_BASE);
  localparam logic [4:0]           LC_MAX  = 5'(ROWS);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_OCC,
    S_RD_COL,
    S_EVAL,
    S_WR_OCC,
    S_WR_COL,
    S_CLR_OCC,
    S_CLR_COL,
    S_DONE
  } state_t;

  state_t                 state_q;
  logic [RW-1:0]          src_q;
  logic signed [DW-1:0]   dst_q;
  logic signed [DW-1:0]   dst_d;
  logic [DATA_W-1:0]      occ_q;
  logic [DATA_W-1:0]      col_q;
  logic [4:0]             lc_q;
  logic                   busy_q;
  logic                   done_q;

  logic                   row_full;
  logic                   src_last;
  logic                   dst_at_src;
  logic [ADDR_W-1:0]      src_addr;
  logic [ADDR_W-1:0]      dst_addr;
  state_t                 next_keep;
  state_t                 next_dec;

  // Full-row count never exceeds the board height.
  function automatic logic [4:0] sat_inc(input logic [4:0] v);
    return (v >= LC_MAX) ? v : v + 5'd1;
  endfunction

  // Where to go once the current source row is finished: the next row up,
  // or, after row 0, either clearing the vacated top rows or finishing.
  function automatic state_t after_row(input logic last, input logic dst_neg);
    if (!last) return S_RD_OCC;
    return dst_neg ? S_DONE : S_CLR_OCC;
  endfunction

  assign row_full   = &occ_q[COLS-1:0];
  assign src_last   = (src_q == '0);
  assign dst_at_src = (dst_q[DW-1] == 1'b0) && (dst_q[RW-1:0] == src_q);
  assign dst_d      = dst_q - ONE_S;
  assign src_addr   = ADDR_W'(src_q);
  assign dst_addr   = ADDR_W'(dst_q[RW-1:0]);
  assign next_keep  = after_row(src_last, dst_q[DW-1]);
  assign next_dec   = after_row(src_last, dst_d[DW-1]);

  assign busy          = busy_q;
  assign done          = done_q;
  assign lines_cleared = lc_q;

  // Port-A mux: host passes straight through in IDLE, engine drives it otherwise.
  always_comb begin
    bus.ram_addr   = bus.host_addr;
    bus.ram_wdata  = bus.host_wdata;
    bus.ram_be     = bus.host_be;
    bus.ram_wren   = 1'b0;
    bus.ram_rden   = 1'b0;
    bus.host_grant = 1'b0;
    if (state_q == S_IDLE) begin
      // a same-cycle start takes the port away from the host
      bus.host_grant = bus.host_req & ~start;
      bus.ram_wren   = bus.host_req &  bus.host_we & ~start;
      bus.ram_rden   = bus.host_req & ~bus.host_we & ~start;
    end else begin
      bus.ram_addr  = src_addr;
      bus.ram_wdata = '0;
      bus.ram_be    = '1;
      case (state_q)
        S_RD_OCC: begin
          bus.ram_addr = src_addr;
          bus.ram_rden = 1'b1;
        end
        S_RD_COL: begin
          bus.ram_addr = src_addr + CB;
          bus.ram_rden = 1'b1;
        end
        S_WR_OCC: begin
          bus.ram_addr  = dst_addr;
          bus.ram_wdata = occ_q;
          bus.ram_wren  = 1'b1;
        end
        S_WR_COL: begin
          bus.ram_addr  = dst_addr + CB;
          bus.ram_wdata = col_q;
          bus.ram_wren  = 1'b1;
        end
        S_CLR_OCC: begin
          bus.ram_addr = dst_addr;
          bus.ram_wren = 1'b1;
        end
        S_CLR_COL: begin
          bus.ram_addr = dst_addr + CB;
          bus.ram_wren = 1'b1;
        end
        default: begin
          bus.ram_wren = 1'b0;
        end
      endcase
    end
  end

  // Capture the row words as they return from VRAM (one cycle after address).
  always_ff @(posedge CLK) begin
    if (state_q == S_RD_COL) occ_q <= bus.ram_q;
    if (state_q == S_EVAL)   col_q <= bus.ram_q;
  end

  // Pass sequencer with registered busy/done/line-count outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      lc_q    <= '0;
      src_q   <= SRC_TOP;
      dst_q   <= DST_TOP;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_RD_OCC;
            busy_q  <= 1'b1;
            lc_q    <= '0;
            src_q   <= SRC_TOP;
            dst_q   <= DST_TOP;
          end
        end
        S_RD_OCC: state_q <= S_RD_COL;
        S_RD_COL: state_q <= S_EVAL;
        S_EVAL: begin
          if (row_full) begin
            lc_q    <= sat_inc(lc_q);
            state_q <= next_keep;
            done_q  <= (next_keep == S_DONE);
            if (!src_last) src_q <= src_q - 1'b1;
          end else if (dst_at_src) begin
            // row already sits where it belongs: no copy needed
            dst_q   <= dst_d;
            state_q <= next_dec;
            done_q  <= (next_dec == S_DONE);
            if (!src_last) src_q <= src_q - 1'b1;
          end else begin
            state_q <= S_WR_OCC;
          end
        end
        S_WR_OCC: state_q <= S_WR_COL;
        S_WR_COL: begin
          dst_q   <= dst_d;
          state_q <= next_dec;
          done_q  <= (next_dec == S_DONE);
          if (!src_last) src_q <= src_q - 1'b1;
        end
        S_CLR_OCC: state_q <= S_CLR_COL;
        S_CLR_COL: begin
          dst_q <= dst_d;
          if (dst_d[DW-1]) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= S_CLR_OCC;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vram_row_clear_sequencer.sv
// Directed bench for the VRAM row-clear sequencer with a behavioural VRAM.
`timescale 1ns/1ps
module tb_vram_row_clear_sequencer;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       start;
  logic       busy;
  logic       done;
  logic [4:0] lines_cleared;

  vram_row_clear_sequencer_if #(.ADDR_W(12), .DATA_W(32)) bus ();

  vram_row_clear_sequencer #(
    .ROWS(20), .COLS(10), .COLOR_BASE(40), .ADDR_W(12), .DATA_W(32)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .start(start),
    .busy(busy),
    .done(done),
    .lines_cleared(lines_cleared),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  // Behavioural single-port VRAM: byte-enabled writes, 1-cycle read latency.
  logic [31:0] mem [0:4095];
  int unsigned wr_cnt = 0;
  logic        stray = 1'b0;
  always @(posedge CLK) begin
    if (bus.ram_wren) begin
      for (int b = 0; b < 4; b++)
        if (bus.ram_be[b]) mem[bus.ram_addr][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
      if (!bus.host_req) begin
        wr_cnt <= wr_cnt + 1;
        if (!((bus.ram_addr < 12'd20) || (bus.ram_addr >= 12'd40 && bus.ram_addr < 12'd60)))
          stray <= 1'b1;
      end
    end
    if (bus.ram_rden) bus.ram_q <= mem[bus.ram_addr];
  end

  int total = 0;
  int bad   = 0;
  logic [31:0] b_occ [20];
  logic [31:0] b_col [20];
  int cyc, dn, g;
  int unsigned w0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge after one granted IDLE write.
  task automatic host_wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.host_req   = 1'b1;
    bus.host_we    = 1'b1;
    bus.host_addr  = a;
    bus.host_wdata = d;
    bus.host_be    = be;
    @(posedge CLK);
    @(negedge CLK);
    bus.host_req   = 1'b0;
  endtask

  task automatic load_board();
    for (int r = 0; r < 20; r++) begin
      host_wr(12'(r), b_occ[r], 4'hF);
      host_wr(12'(r + 40), b_col[r], 4'hF);
    end
  endtask

  // Pulse start and count busy cycles and done pulses until IDLE (bounded).
  task automatic run_pass(output int c, output int d);
    start = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    start = 1'b0;
    c = 0;
    d = 0;
    for (int i = 0; i < 300; i++) begin
      if (!busy) break;
      c++;
      if (done) d++;
      @(negedge CLK);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET          = 1'b1;
    start          = 1'b0;
    bus.host_req   = 1'b0;
    bus.host_we    = 1'b0;
    bus.host_addr  = '0;
    bus.host_wdata = '0;
    bus.host_be    = '0;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_lines", 32'(lines_cleared), 32'd0);
    chk("rst_wren", 32'(bus.ram_wren), 32'd0);
    chk("rst_rden", 32'(bus.ram_rden), 32'd0);
    chk("rst_grant", 32'(bus.host_grant), 32'd0);
    @(negedge CLK);

    // IDLE host write is passed through combinationally
    bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 12'h258;
    bus.host_wdata = 32'hA5; bus.host_be = 4'hF;
    #1;
    chk("idle_wren", 32'(bus.ram_wren), 32'd1);
    chk("idle_grant", 32'(bus.host_grant), 32'd1);
    chk("idle_addr", 32'(bus.ram_addr), 32'h258);
    chk("idle_wdata", bus.ram_wdata, 32'hA5);
    @(posedge CLK); @(negedge CLK);
    bus.host_req = 1'b0;
    chk("idle_mem", mem[12'h258], 32'hA5);
    // IDLE host read
    bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 12'h258;
    #1;
    chk("idle_rden", 32'(bus.ram_rden), 32'd1);
    chk("idle_rd_nowr", 32'(bus.ram_wren), 32'd0);
    @(posedge CLK); @(negedge CLK);
    bus.host_req = 1'b0;
    chk("idle_rdq", bus.ram_q, 32'hA5);
    // byte enables reach the RAM
    host_wr(12'h259, 32'h0, 4'hF);
    host_wr(12'h259, 32'hFFFF_FFFF, 4'b0011);
    chk("idle_be", mem[12'h259], 32'h0000_FFFF);

    // Empty board: nothing written, 61 busy cycles
    for (int r = 0; r < 20; r++) begin b_occ[r] = 32'h0; b_col[r] = 32'h10 + 32'(r); end
    load_board();
    w0 = wr_cnt;
    run_pass(cyc, dn);
    chk("empty_cycles", 32'(cyc), 32'd61);
    chk("empty_done", 32'(dn), 32'd1);
    chk("empty_lines", 32'(lines_cleared), 32'd0);
    chk("empty_writes", wr_cnt - w0, 32'd0);
    chk("empty_col5", mem[45], 32'h15);

    // Bottom row full, rows above distinct: everything shifts down one
    for (int r = 0; r < 19; r++) begin
      b_occ[r] = 32'(r * 37 + 5);
      b_col[r] = 32'hC000_0000 | (32'(r) * 32'h111);
    end
    b_occ[19] = 32'h3FF; b_col[19] = 32'hDEAD_BEEF;
    load_board();
    w0 = wr_cnt;
    run_pass(cyc, dn);
    chk("one_cycles", 32'(cyc), 32'd101);
    chk("one_done", 32'(dn), 32'd1);
    chk("one_lines", 32'(lines_cleared), 32'd1);
    chk("one_writes", wr_cnt - w0, 32'd40);
    for (int r = 0; r < 19; r++) begin
      chk($sformatf("one_occ%0d", r + 1), mem[r + 1], 32'(r * 37 + 5));
      chk($sformatf("one_col%0d", r + 1), mem[r + 41], 32'hC000_0000 | (32'(r) * 32'h111));
    end
    chk("one_occ0", mem[0], 32'h0);
    chk("one_col0", mem[40], 32'h0);

    // Four full bottom rows, row 15 nearly empty: shift by four
    for (int r = 0; r < 15; r++) begin b_occ[r] = 32'(r + 2); b_col[r] = 32'h100 + 32'(r); end
    b_occ[15] = 32'h001; b_col[15] = 32'h777;
    for (int r = 16; r < 20; r++) begin b_occ[r] = 32'h3FF; b_col[r] = 32'h200 + 32'(r); end
    load_board();
    w0 = wr_cnt;
    run_pass(cyc, dn);
    chk("four_cycles", 32'(cyc), 32'd101);
    chk("four_lines", 32'(lines_cleared), 32'd4);
    chk("four_writes", wr_cnt - w0, 32'd40);
    chk("four_row19", mem[19], 32'h001);
    chk("four_col19", mem[59], 32'h777);
    for (int r = 0; r < 15; r++) chk($sformatf("four_occ%0d", r + 4), mem[r + 4], 32'(r + 2));
    for (int r = 0; r < 4; r++) begin
      chk($sformatf("four_clr_occ%0d", r), mem[r], 32'h0);
      chk($sformatf("four_clr_col%0d", r), mem[r + 40], 32'h0);
    end

    // Whole board full: every row cleared, count reaches ROWS
    for (int r = 0; r < 20; r++) begin b_occ[r] = 32'h3FF; b_col[r] = 32'hF0 + 32'(r); end
    load_board();
    w0 = wr_cnt;
    run_pass(cyc, dn);
    chk("full_cycles", 32'(cyc), 32'd101);
    chk("full_lines", 32'(lines_cleared), 32'd20);
    chk("full_writes", wr_cnt - w0, 32'd40);
    chk("full_row0", mem[0], 32'h0);
    chk("full_col19", mem[59], 32'h0);

    // start and host write in the same IDLE cycle; host held through the pass
    for (int r = 0; r < 20; r++) begin b_occ[r] = 32'h0; b_col[r] = 32'h0; end
    load_board();
    start = 1'b1;
    bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 12'h301;
    bus.host_wdata = 32'h55; bus.host_be = 4'hF;
    #1;
    chk("same_grant", 32'(bus.host_grant), 32'd0);
    chk("same_wren", 32'(bus.ram_wren), 32'd0);
    @(posedge CLK); @(negedge CLK);
    start = 1'b0;
    cyc = 0; g = 0;
    for (int i = 0; i < 300; i++) begin
      if (!busy) break;
      cyc++;
      if (bus.host_grant || bus.ram_wren) g++;
      @(negedge CLK);
    end
    chk("stall_cycles", 32'(cyc), 32'd61);
    chk("stall_grants", 32'(g), 32'd0);
    chk("after_grant", 32'(bus.host_grant), 32'd1);
    chk("after_addr", 32'(bus.ram_addr), 32'h301);
    @(posedge CLK); @(negedge CLK);
    bus.host_req = 1'b0;
    chk("after_mem", mem[12'h301], 32'h55);

    // Reset in the first WR_OCC aborts the pass
    for (int r = 0; r < 19; r++) begin b_occ[r] = 32'(r * 37 + 5); b_col[r] = 32'h0; end
    b_occ[19] = 32'h3FF; b_col[19] = 32'h0;
    load_board();
    start = 1'b1;
    @(posedge CLK); @(negedge CLK);
    start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.ram_wren) break;
      @(negedge CLK);
    end
    chk("abort_wr_addr", 32'(bus.ram_addr), 32'd19);
    chk("abort_lines_pre", 32'(lines_cleared), 32'd1);
    w0 = wr_cnt;
    RESET = 1'b1;
    @(posedge CLK); @(negedge CLK);
    RESET = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_wren", 32'(bus.ram_wren), 32'd0);
    chk("abort_lines", 32'(lines_cleared), 32'd0);
    repeat (10) @(negedge CLK);
    chk("abort_writes", wr_cnt - w0, 32'd1);
    chk("abort_idle", 32'(busy), 32'd0);

    chk("no_stray_writes", 32'(stray), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
